// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit slice.
package mdu_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } msc_state_e;

    localparam int MUL_LATENCY = 18;

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin pick: first eligible requester at or after rr_ptr_i, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] rr_ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_o
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [IW:0]    sum;

    // Rotating a doubled copy puts the pointer's requester at bit 0.
    assign doubled = {eligible_i, eligible_i};
    assign rotated = N'(doubled >> rr_ptr_i);

    always_comb begin
        any_o = 1'b0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && rotated[k]) begin
                any_o = 1'b1;
                sum   = {1'b0, rr_ptr_i} + (IW+1)'(k);
            end
        end
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        grant_idx_o = sum[IW-1:0];
        grant_o     = any_o ? (N'(1) << sum[IW-1:0]) : '0;
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one multiplier between NUM_REQ requesters: round-robin grant, operands held until the
// result is consumed, result and tag routed back to the owner, per-requester flush.
module mul_share_ctrl
    import mdu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][1:0]           req_type,
    input  logic [NUM_REQ-1:0][31:0]          req_rs1,
    input  logic [NUM_REQ-1:0][31:0]          req_rs2,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag,
    input  logic [NUM_REQ-1:0]                req_flush,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output logic [31:0]                       resp_data,
    output logic [TAG_W-1:0]                  resp_tag,
    output logic                              mul_in_valid,
    output logic [1:0]                        mul_type,
    output logic [31:0]                       multiplicand,
    output logic [31:0]                       multiplier,
    output logic                              cpu_busy,
    input  logic [31:0]                       mul_out,
    input  logic                              mul_out_valid,
    input  logic                              mul_busy
);

    localparam int IW = $clog2(NUM_REQ);

    msc_state_e       state_q;
    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    owner_q;
    logic             kill_q;
    mul_op_e          mul_type_q;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [TAG_W-1:0] tag_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic [IW-1:0]      next_ptr;
    logic               in_idle;
    logic               in_issue;
    logic               in_wait;
    logic               owner_flush;
    logic               op_done;

    // Flush beats valid so a requester being killed can never be granted.
    assign eligible = req_valid & ~req_flush;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .eligible_i  (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    assign next_ptr    = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IW'(1);
    assign in_idle     = (state_q == ST_IDLE);
    assign in_issue    = (state_q == ST_ISSUE);
    assign in_wait     = (state_q == ST_WAIT);
    assign owner_flush = req_flush[owner_q];

    // Result leaves the multiplier when the owner takes it or it is being discarded.
    assign op_done = in_wait & mul_out_valid & (kill_q | owner_flush | resp_ready[owner_q]);

    assign req_ready    = (in_idle && !rst) ? arb_grant : '0;
    assign mul_in_valid = in_issue & ~owner_flush & ~mul_busy;
    assign cpu_busy     = in_wait & ~op_done;
    assign mul_type     = mul_type_q;
    assign multiplicand = rs1_q;
    assign multiplier   = rs2_q;
    assign resp_data    = mul_out;
    assign resp_tag     = tag_q;

    always_comb begin
        resp_valid          = '0;
        resp_valid[owner_q] = in_wait & mul_out_valid & ~kill_q & ~owner_flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            kill_q     <= 1'b0;
            mul_type_q <= MUL;
            rs1_q      <= '0;
            rs2_q      <= '0;
            tag_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        owner_q    <= arb_idx;
                        mul_type_q <= mul_op_e'(req_type[arb_idx]);
                        rs1_q      <= req_rs1[arb_idx];
                        rs2_q      <= req_rs2[arb_idx];
                        tag_q      <= req_tag[arb_idx];
                        rr_ptr_q   <= next_ptr;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (owner_flush) begin
                        state_q <= ST_IDLE;
                    end else if (!mul_busy) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Kill stays set so a one-cycle flush still discards a later result.
                    if (owner_flush) begin
                        kill_q <= 1'b1;
                    end
                    if (op_done) begin
                        kill_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl with a behavioural 18-cycle multiplier attached.
module tb_mul_share_ctrl;
    import mdu_pkg::*;

    localparam int N  = 2;
    localparam int TW = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid, req_ready, req_flush, resp_valid, resp_ready;
    logic [N-1:0][1:0]    req_type;
    logic [N-1:0][31:0]   req_rs1, req_rs2;
    logic [N-1:0][TW-1:0] req_tag;
    logic [31:0]          resp_data, multiplicand, multiplier, mul_out;
    logic [TW-1:0]        resp_tag;
    logic                 mul_in_valid, cpu_busy, mul_out_valid, mul_busy;
    logic [1:0]           mul_type;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_share_ctrl #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .req_flush(req_flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
        .mul_in_valid(mul_in_valid), .mul_type(mul_type), .multiplicand(multiplicand),
        .multiplier(multiplier), .cpu_busy(cpu_busy), .mul_out(mul_out),
        .mul_out_valid(mul_out_valid), .mul_busy(mul_busy)
    );

    // 64-bit product with operand extension chosen by op type.
    function automatic logic [31:0] ref_mul(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {{32{((t == 2'b01) || (t == 2'b10)) & a[31]}}, a};
        eb = {{32{(t == 2'b01) & b[31]}}, b};
        p  = ea * eb;
        return (t == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Multiplier stand-in: start pulse, MUL_LATENCY cycles to DONE, DONE held while cpu_busy.
    typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mst_t;
    mst_t        m_st;
    int          m_cnt;
    logic [31:0] m_a, m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= M_IDLE; m_cnt <= 0; m_a <= '0; m_b <= '0;
        end else begin
            case (m_st)
                M_IDLE: if (mul_in_valid) begin
                    m_st <= M_BUSY; m_cnt <= MUL_LATENCY - 1; m_a <= multiplicand; m_b <= multiplier;
                end
                M_BUSY: if (m_cnt == 1) m_st <= M_DONE; else m_cnt <= m_cnt - 1;
                default: if (!cpu_busy) m_st <= M_IDLE;
            endcase
        end
    end

    assign mul_busy      = (m_st != M_IDLE);
    assign mul_out_valid = (m_st == M_DONE);
    assign mul_out       = ref_mul(mul_type, m_a, m_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                           input logic [TW-1:0] tg);
        req_valid[r] = 1'b1; req_type[r] = t; req_rs1[r] = a; req_rs2[r] = b; req_tag[r] = tg;
    endtask

    task automatic do_reset();
        req_valid = '0; req_flush = '0; resp_ready = '1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Waits (bounded) for resp_valid[r]; returns at the negedge where it was seen.
    task automatic wait_resp(input int r, output logic [31:0] data, output logic [TW-1:0] tg);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_valid[r] && n < 100) begin n++; @(negedge clk); end
        chk("resp_arrives", 32'(n < 100), 32'd1);
        data = resp_data; tg = resp_tag;
    endtask

    // Issues one op on requester r (resp_ready assumed high) and measures fire-to-resp_valid cycles.
    task automatic do_op(input int r, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tg, output int lat, output logic [31:0] data,
                         output logic [TW-1:0] rtag);
        int w;
        set_req(r, t, a, b, tg);
        w = 0;
        @(negedge clk);
        while (!req_ready[r] && w < 50) begin w++; @(negedge clk); end
        chk("grant_seen", 32'(req_ready[r]), 32'd1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid[r] && lat < 100);
        data = resp_data; rtag = resp_tag;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]    t;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [TW-1:0] tag;
        logic [31:0]   exp;
    } vec_t;

    typedef struct {
        logic [1:0]    t;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [TW-1:0] tag;
    } op_t;

    function automatic logic [31:0] rand_operand();
        logic [31:0] c [5];
        c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'hFFFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h7FFF_FFFF;
        return ($urandom_range(0, 3) == 0) ? c[$urandom_range(0, 4)] : $urandom;
    endfunction

    // Transaction-level model: at most one op in flight, grants follow a rotating pointer.
    task automatic rand_phase();
        op_t          pend [N];
        bit           has  [N];
        op_t          infl_op;
        bit           infl;
        int           own, mptr, grants, resps, exp_g, idx, g, drain;
        logic [N-1:0] exp_rr, exp_rv;
        infl = 0; own = 0; mptr = 0; grants = 0; resps = 0; drain = 0;
        for (int i = 0; i < N; i++) has[i] = 0;
        for (int cyc = 0; cyc < 700 && drain < 120; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!has[i] && cyc < 580 && $urandom_range(0, 3) == 0) begin
                    pend[i].t = 2'($urandom_range(0, 3)); pend[i].a = rand_operand();
                    pend[i].b = rand_operand(); pend[i].tag = TW'($urandom);
                    has[i] = 1;
                end
                req_valid[i] = has[i];
                req_type[i] = pend[i].t; req_rs1[i] = pend[i].a; req_rs2[i] = pend[i].b;
                req_tag[i] = pend[i].tag;
                resp_ready[i] = ($urandom_range(0, 2) != 0);
            end
            if (cyc >= 580) drain++;
            @(negedge clk);
            exp_g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (exp_g < 0 && req_valid[idx]) exp_g = idx;
            end
            exp_rr = '0;
            if (!infl && exp_g >= 0) exp_rr[exp_g] = 1'b1;
            chk("rand_grant", 32'(req_ready), 32'(exp_rr));
            if (req_ready != '0) begin
                g = req_ready[0] ? 0 : 1;
                infl = 1; own = g; infl_op = pend[g]; has[g] = 0; mptr = (g + 1) % N; grants++;
            end else if (resp_valid != '0) begin
                exp_rv = '0;
                if (infl) exp_rv[own] = 1'b1;
                chk("rand_owner", 32'(resp_valid), 32'(exp_rv));
                chk("rand_data", resp_data, ref_mul(infl_op.t, infl_op.a, infl_op.b));
                chk("rand_tag", 32'(resp_tag), 32'(infl_op.tag));
                if (infl && resp_ready[own]) begin infl = 0; resps++; end
            end
            @(posedge clk); #1;
        end
        chk("rand_activity", 32'(grants > 8), 32'd1);
        chk("rand_all_returned", 32'(resps), 32'(grants));
        resp_ready = '1;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        vec_t          vecs [9];
        int            lat, bad, n;
        bit            hit;
        logic [31:0]   d, d0;
        logic [TW-1:0] tg;

        vecs[0] = '{2'b00, 32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB};
        vecs[1] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE};
        vecs[2] = '{2'b01, 32'h8000_0000,  32'd2,         5'd3, 32'hFFFF_FFFF};
        vecs[3] = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF};
        vecs[4] = '{2'b00, 32'h0001_0000,  32'h0001_0000, 5'd5, 32'h0000_0000};
        vecs[5] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6, 32'h0000_0000};
        vecs[6] = '{2'b11, 32'h8000_0000,  32'd4,         5'd7, 32'h0000_0002};
        vecs[7] = '{2'b01, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 5'd8, 32'h3FFF_FFFF};
        vecs[8] = '{2'b10, 32'h8000_0000,  32'h8000_0000, 5'd9, 32'hC000_0000};

        rst = 1'b1; req_valid = '0; req_flush = '0; resp_ready = '1;
        req_type = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
        #12;
        chk("rst_ctrl", {24'b0, req_ready, resp_valid, mul_in_valid, cpu_busy, mul_type}, 32'd0);
        chk("rst_operands", multiplicand | multiplier, 32'd0);
        chk("rst_tag", 32'(resp_tag), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors alternate requesters; each must take 19 cycles from fire to resp_valid.
        for (int i = 0; i < 9; i++) begin
            do_op(i % 2, vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].tag, lat, d, tg);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
            chk($sformatf("vec%0d_tag", i), 32'(tg), 32'(vecs[i].tag));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(MUL_LATENCY + 1));
        end

        // Round-robin: both valid from reset, then rotation to req1, then back to req0.
        do_reset();
        set_req(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        set_req(1, 2'b01, 32'h8000_0000, 32'd2, 5'd4);
        @(negedge clk);
        chk("rr_first_req0", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        set_req(0, 2'b00, 32'd3, 32'd5, 5'd5);
        wait_resp(0, d, tg);
        chk("rr_r1_data", d, 32'hFFFF_FFFE);
        chk("rr_r1_tag", 32'(tg), 32'd3);
        chk("rr_one_in_flight", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rr_second_req1", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_resp(1, d, tg);
        chk("rr_r2_data", d, 32'hFFFF_FFFF);
        chk("rr_r2_tag", 32'(tg), 32'd4);
        @(negedge clk);
        chk("rr_third_req0", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_resp(0, d, tg);
        chk("rr_r3_data", d, 32'd15);
        @(posedge clk); #1;

        // Owner stalls the result for 10 cycles while the other requester waits.
        resp_ready[0] = 1'b0;
        set_req(0, 2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd6);
        @(negedge clk);
        chk("stall_grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 2'b00, 32'd2, 32'd3, 5'd7);
        wait_resp(0, d0, tg);
        chk("stall_data", d0, 32'h3FFF_FFFF);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid !== 2'b01 || resp_data !== d0 || resp_tag !== 5'd6 || cpu_busy !== 1'b1 ||
                req_ready !== 2'b00) bad++;
        end
        chk("stall_hold_cycles_bad", 32'(bad), 32'd0);
        @(posedge clk); #1;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        chk("stall_fire", {30'b0, resp_valid}, 32'b01);
        @(negedge clk);
        chk("stall_next_grant", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_resp(1, d, tg);
        chk("stall_r1_data", d, 32'd6);
        @(posedge clk); #1;

        // Flush owner in WAIT: result is discarded and the multiplier released.
        set_req(0, 2'b00, 32'd9, 32'd9, 5'd8);
        @(negedge clk);
        chk("flushw_grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 2'b11, 32'h8000_0000, 32'd4, 5'd9);
        repeat (4) @(posedge clk);
        #1 req_flush[0] = 1'b1;
        bad = 0;
        @(negedge clk);
        if (resp_valid != '0 || req_ready != '0) bad++;
        @(posedge clk); #1;
        req_flush[0] = 1'b0;
        hit = 0; n = 0;
        while (!hit && n < 40) begin
            @(negedge clk); n++;
            if (resp_valid != '0 || req_ready != '0) bad++;
            if (mul_out_valid) hit = 1;
        end
        chk("flushw_done_seen", 32'(hit), 32'd1);
        chk("flushw_cpu_busy_low", 32'(cpu_busy), 32'd0);
        chk("flushw_no_resp", 32'(bad), 32'd0);
        @(negedge clk);
        chk("flushw_other_granted", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_resp(1, d, tg);
        chk("flushw_r1_data", d, 32'd2);
        @(posedge clk); #1;

        // Flush in IDLE blocks the grant; flush in ISSUE suppresses the start pulse.
        set_req(0, 2'b00, 32'd1, 32'd1, 5'd10);
        req_flush[0] = 1'b1;
        bad = 0;
        repeat (3) begin @(negedge clk); if (req_ready != '0) bad++; end
        chk("flush_idle_no_ready", 32'(bad), 32'd0);
        @(posedge clk); #1;
        req_flush[0] = 1'b0;
        @(negedge clk);
        chk("flush_issue_grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0; req_flush[0] = 1'b1;
        @(negedge clk);
        chk("flush_issue_no_start", 32'(mul_in_valid), 32'd0);
        @(posedge clk); #1;
        req_flush[0] = 1'b0;
        bad = 0;
        repeat (25) begin @(negedge clk); if (mul_in_valid || resp_valid != '0 || cpu_busy) bad++; end
        chk("flush_issue_quiet", 32'(bad), 32'd0);
        @(posedge clk); #1;
        do_op(1, 2'b10, 32'h8000_0000, 32'h8000_0000, 5'd11, lat, d, tg);
        chk("post_flush_data", d, 32'hC000_0000);
        chk("post_flush_latency", 32'(lat), 32'(MUL_LATENCY + 1));

        // Reset in WAIT clears every output immediately; next op behaves normally.
        set_req(0, 2'b11, 32'd5, 32'd6, 5'd12);
        @(negedge clk);
        chk("rstw_grant", 32'(req_ready), 32'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("rstw_busy_before", 32'(cpu_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_ctrl", {24'b0, req_ready, resp_valid, mul_in_valid, cpu_busy, mul_type}, 32'd0);
        chk("rstw_operands", multiplicand | multiplier, 32'd0);
        chk("rstw_tag", 32'(resp_tag), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        do_op(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, lat, d, tg);
        chk("rstw_new_data", d, 32'hFFFF_FFFF);
        chk("rstw_new_tag", 32'(tg), 32'd13);
        chk("rstw_new_latency", 32'(lat), 32'(MUL_LATENCY + 1));

        do_reset();
        rand_phase();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
